mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / data-port memory arbiter:
// FSM state encoding, default fairness limit and counter sizing helper.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_e;

   localparam int DEFAULT_FAIR_LIMIT = 4;

   // Bits needed to count 0..limit inclusive.
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-requester, data-requester and shared-memory signals.
// slave = arbiter view, master = environment (requesters + memory) view.
interface mem_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_cancel;
   logic                  if_done;
   logic [DATA_WIDTH-1:0] if_rdata;

   logic                  d_req;
   logic                  d_we;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic [BE_WIDTH-1:0]   d_be;
   logic                  d_done;
   logic [DATA_WIDTH-1:0] d_rdata;

   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [BE_WIDTH-1:0]   mem_be;
   logic                  mem_ack;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, if_cancel,
      output if_done, if_rdata,
      input  d_req, d_we, d_addr, d_wdata, d_be,
      output d_done, d_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ack, mem_rdata
   );

   modport master (
      output if_req, if_addr, if_cancel,
      input  if_done, if_rdata,
      output d_req, d_we, d_addr, d_wdata, d_be,
      input  d_done, d_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch + data) onto one single-outstanding memory port,
// with data priority bounded by a starvation counter protecting the fetch side.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int FAIR_LIMIT = DEFAULT_FAIR_LIMIT
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int CNT_W    = cnt_width(FAIR_LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FAIR_LIMIT);

   state_e                state_q,     state_d;
   logic                  mem_req_q,   mem_req_d;
   logic                  mem_we_q,    mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [BE_WIDTH-1:0]   mem_be_q,    mem_be_d;
   logic                  drop_q,      drop_d;
   logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;

   logic if_eff;
   logic drop_now;

   // A cancel in the same cycle as the request withdraws it from arbitration.
   assign if_eff   = bus.if_req && !bus.if_cancel;
   // A cancel arriving together with the ack must also suppress that done.
   assign drop_now = drop_q || bus.if_cancel;

   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;
      drop_d       = drop_q;
      starve_cnt_d = starve_cnt_q;

      case (state_q)
         IDLE: begin
            drop_d = 1'b0;
            if (!if_eff) begin
               starve_cnt_d = '0;
            end
            if (bus.d_req && (!if_eff || starve_cnt_q < CNT_MAX)) begin
               state_d     = GRANT_D;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.d_we;
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_wdata;
               mem_be_d    = bus.d_be;
               if (if_eff && starve_cnt_q < CNT_MAX) begin
                  starve_cnt_d = starve_cnt_q + CNT_W'(1);
               end
            end else if (if_eff) begin
               state_d      = GRANT_I;
               mem_req_d    = 1'b1;
               mem_we_d     = 1'b0;
               mem_addr_d   = bus.if_addr;
               mem_wdata_d  = '0;
               mem_be_d     = {BE_WIDTH{1'b1}};
               starve_cnt_d = '0;
            end
         end
         GRANT_I: begin
            drop_d = drop_now;
            if (bus.mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               drop_d    = 1'b0;
            end
         end
         GRANT_D: begin
            if (bus.mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            drop_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= '0;
         drop_q       <= 1'b0;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
         drop_q       <= drop_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_be    = mem_be_q;

   assign bus.if_done  = (state_q == GRANT_I) && bus.mem_ack && !drop_now;
   assign bus.d_done   = (state_q == GRANT_D) && bus.mem_ack;
   assign bus.if_rdata = bus.mem_rdata;
   assign bus.d_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: grant order, latency, fairness,
// cancel, write latching and reset abandonment.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   mem_arbiter #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .FAIR_LIMIT(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic quiet();
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.if_cancel = 1'b0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.d_be      = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
   endtask

   initial begin
      int dcnt;
      int icnt;
      tests = 0;
      fails = 0;
      quiet();
      rst_n = 1'b0;

      // Reset, with a stray ack present
      tick();
      bus.mem_ack = 1'b1;
      tick();
      settle();
      chk("rst_state",   64'(dut.state_q), 64'(IDLE));
      chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
      chk("rst_mem_we",  64'(bus.mem_we), 64'd0);
      chk("rst_addr",    64'(bus.mem_addr), 64'd0);
      chk("rst_wdata",   64'(bus.mem_wdata), 64'd0);
      chk("rst_be",      64'(bus.mem_be), 64'd0);
      chk("rst_if_done", 64'(bus.if_done), 64'd0);
      chk("rst_d_done",  64'(bus.d_done), 64'd0);
      chk("rst_starve",  64'(dut.starve_cnt_q), 64'd0);
      bus.mem_ack = 1'b0;
      rst_n = 1'b1;
      tick();
      $display("[TB] txn reset done");

      // Single fetch, zero-wait memory
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h100;
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hCAFE_0001;
      settle();
      chk("f1_mem_req",  64'(bus.mem_req), 64'd1);
      chk("f1_mem_addr", 64'(bus.mem_addr), 64'h100);
      chk("f1_mem_we",   64'(bus.mem_we), 64'd0);
      chk("f1_mem_be",   64'(bus.mem_be), 64'hF);
      chk("f1_if_done",  64'(bus.if_done), 64'd1);
      chk("f1_if_rdata", 64'(bus.if_rdata), 64'hCAFE_0001);
      chk("f1_d_done",   64'(bus.d_done), 64'd0);
      tick();
      quiet();
      settle();
      chk("f1_idle",     64'(dut.state_q), 64'(IDLE));
      chk("f1_req_low",  64'(bus.mem_req), 64'd0);
      $display("[TB] txn fetch 0x100");

      // Simultaneous fetch and data read: data first, then fetch
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h300;
      bus.d_req   = 1'b1;
      bus.d_addr  = 32'h200;
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h1234_5678;
      settle();
      chk("both_d_addr",  64'(bus.mem_addr), 64'h200);
      chk("both_d_done",  64'(bus.d_done), 64'd1);
      chk("both_d_rdata", 64'(bus.d_rdata), 64'h1234_5678);
      chk("both_no_if",   64'(bus.if_done), 64'd0);
      tick();
      bus.d_req   = 1'b0;
      bus.mem_ack = 1'b0;
      settle();
      chk("both_starve1", 64'(dut.starve_cnt_q), 64'd1);
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h0BAD_F00D;
      settle();
      chk("both_i_addr",  64'(bus.mem_addr), 64'h300);
      chk("both_if_done", 64'(bus.if_done), 64'd1);
      chk("both_starve0", 64'(dut.starve_cnt_q), 64'd0);
      tick();
      quiet();
      $display("[TB] txn read 0x200 then fetch 0x300");

      // Fairness: both held, ack always high -> D,D,D,D then I
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h500;
      bus.d_req   = 1'b1;
      bus.d_addr  = 32'h600;
      bus.mem_ack = 1'b1;
      dcnt = 0;
      icnt = 0;
      for (int c = 0; c < 10; c++) begin
         settle();
         chk($sformatf("fair_d_c%0d", c), 64'(bus.d_done),
             64'((c % 2 == 1) && (c < 8)));
         chk($sformatf("fair_i_c%0d", c), 64'(bus.if_done), 64'(c == 9));
         if (bus.d_done) dcnt++;
         if (bus.if_done) icnt++;
         if (c == 9) chk("fair_starve0", 64'(dut.starve_cnt_q), 64'd0);
         tick();
      end
      chk("fair_d_grants", 64'(dcnt), 64'd4);
      chk("fair_i_grants", 64'(icnt), 64'd1);
      quiet();
      tick();
      $display("[TB] txn fairness 4 data + 1 fetch");

      // Fetch cancelled during a 3-wait access
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h700;
      tick();
      settle();
      chk("cx_w1_req", 64'(bus.mem_req), 64'd1);
      tick();
      bus.if_cancel = 1'b1;
      settle();
      chk("cx_w2_req",  64'(bus.mem_req), 64'd1);
      chk("cx_w2_done", 64'(bus.if_done), 64'd0);
      tick();
      bus.if_cancel = 1'b0;
      bus.if_req    = 1'b0;
      settle();
      chk("cx_w3_req", 64'(bus.mem_req), 64'd1);
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h7777_7777;
      settle();
      chk("cx_ack_req",  64'(bus.mem_req), 64'd1);
      chk("cx_ack_done", 64'(bus.if_done), 64'd0);
      tick();
      bus.mem_ack = 1'b0;
      settle();
      chk("cx_idle",    64'(dut.state_q), 64'(IDLE));
      chk("cx_req_low", 64'(bus.mem_req), 64'd0);
      chk("cx_drop",    64'(dut.drop_q), 64'd0);
      $display("[TB] txn fetch 0x700 cancelled");

      // Cancel coinciding with the ack also suppresses done
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h704;
      tick();
      bus.mem_ack   = 1'b1;
      bus.if_cancel = 1'b1;
      settle();
      chk("cxa_done", 64'(bus.if_done), 64'd0);
      tick();
      quiet();
      $display("[TB] txn fetch 0x704 cancelled at ack");

      // Cancel in IDLE masks the fetch request
      bus.if_req    = 1'b1;
      bus.if_cancel = 1'b1;
      bus.if_addr   = 32'h708;
      tick();
      quiet();
      settle();
      chk("cxi_state", 64'(dut.state_q), 64'(IDLE));
      chk("cxi_req",   64'(bus.mem_req), 64'd0);
      $display("[TB] txn fetch 0x708 masked in idle");

      // Write, 2-wait memory, requester inputs change while granted
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h40;
      bus.d_wdata = 32'hDEAD_BEEF;
      bus.d_be    = 4'b0011;
      tick();
      bus.d_addr  = 32'h44;
      bus.d_wdata = 32'h0;
      bus.d_be    = 4'hF;
      bus.d_we    = 1'b0;
      for (int w = 0; w < 2; w++) begin
         settle();
         chk($sformatf("wr_w%0d_we", w),    64'(bus.mem_we), 64'd1);
         chk($sformatf("wr_w%0d_addr", w),  64'(bus.mem_addr), 64'h40);
         chk($sformatf("wr_w%0d_wdata", w), 64'(bus.mem_wdata), 64'hDEAD_BEEF);
         chk($sformatf("wr_w%0d_be", w),    64'(bus.mem_be), 64'h3);
         chk($sformatf("wr_w%0d_done", w),  64'(bus.d_done), 64'd0);
         tick();
      end
      bus.mem_ack = 1'b1;
      settle();
      chk("wr_ack_done", 64'(bus.d_done), 64'd1);
      chk("wr_ack_addr", 64'(bus.mem_addr), 64'h40);
      tick();
      quiet();
      settle();
      chk("wr_req_low", 64'(bus.mem_req), 64'd0);
      $display("[TB] txn write 0x40 = 0xDEADBEEF be=0x3");

      // Reset during a data wait, then a stray ack
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h80;
      tick();
      settle();
      chk("rd_rst_req", 64'(bus.mem_req), 64'd1);
      rst_n = 1'b0;
      tick();
      rst_n       = 1'b1;
      bus.d_req   = 1'b0;
      bus.mem_ack = 1'b1;
      settle();
      chk("rd_rst_state", 64'(dut.state_q), 64'(IDLE));
      chk("rd_rst_mreq",  64'(bus.mem_req), 64'd0);
      chk("rd_rst_dd",    64'(bus.d_done), 64'd0);
      tick();
      bus.mem_ack = 1'b0;
      settle();
      chk("rd_rst_dd2",   64'(bus.d_done), 64'd0);
      chk("rd_rst_mreq2", 64'(bus.mem_req), 64'd0);
      $display("[TB] txn read 0x80 aborted by reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
